// File: rtl/board_row_server.sv
// Row-fetch responder: copies one board row from RAM into a shadow buffer,
// then commits it to Row in a single cycle so a scanline never sees a torn row.
module board_row_server #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int CELL_W  = 16,
   parameter int ADDR_W  = 8
) (
   input  logic                             Clk,
   input  logic                             reset_n,
   input  logic                             LD_Row,
   input  logic [7:0]                       rowNum,
   output logic [ADDR_W-1:0]                ram_addr,
   output logic                             ram_rd,
   input  logic [CELL_W-1:0]                ram_rdata,
   output logic [BOARD_W-1:0][CELL_W-1:0]   Row,
   output logic                             rowReady,
   output logic                             busy,
   output logic                             err_range
);

   localparam int CW = $clog2(BOARD_W);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;
   typedef logic [BOARD_W-1:0][CELL_W-1:0] row_t;

   state_t        state;
   logic          ld_q;
   logic          rd_d;
   logic [CW-1:0] col;
   logic [CW-1:0] col_d;
   row_t          shadow;
   row_t          shadow_nxt;
   logic          pend_v;
   logic [7:0]    pend_row;
   logic          pend_ok;

   logic          req;
   logic          in_range;
   logic          launch;
   logic [7:0]    l_row;
   logic          l_ok;

   always_comb begin
      req        = LD_Row & ~ld_q;
      in_range   = rowNum < 8'(BOARD_H);
      shadow_nxt = shadow;
      if (rd_d)
         shadow_nxt[col_d] = ram_rdata;
      launch = 1'b0;
      l_row  = rowNum;
      l_ok   = in_range;
      if (state == IDLE) begin
         launch = req;
      end else if (state == COMMIT) begin
         // a fresh edge in the commit cycle supersedes the queued request
         launch = req | pend_v;
         if (!req) begin
            l_row = pend_row;
            l_ok  = pend_ok;
         end
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ld_q      <= 1'b0;
         rd_d      <= 1'b0;
         col       <= '0;
         col_d     <= '0;
         shadow    <= '0;
         Row       <= '0;
         rowReady  <= 1'b0;
         busy      <= 1'b0;
         err_range <= 1'b0;
         ram_rd    <= 1'b0;
         ram_addr  <= '0;
         pend_v    <= 1'b0;
         pend_row  <= '0;
         pend_ok   <= 1'b0;
      end else begin
         ld_q     <= LD_Row;
         rd_d     <= ram_rd;
         col_d    <= col;
         shadow   <= shadow_nxt;
         rowReady <= 1'b0;

         if (state == COMMIT) begin
            pend_v <= 1'b0;
         end else if (req && state != IDLE) begin
            pend_v   <= 1'b1;
            pend_row <= rowNum;
            pend_ok  <= in_range;
         end

         unique case (state)
            IDLE, COMMIT: begin
               if (launch) begin
                  busy <= 1'b1;
                  if (l_ok) begin
                     state     <= FETCH;
                     col       <= '0;
                     ram_rd    <= 1'b1;
                     ram_addr  <= ADDR_W'(l_row) * ADDR_W'(BOARD_W);
                     err_range <= 1'b0;
                  end else begin
                     state     <= COMMIT;
                     shadow    <= '0;
                     Row       <= '0;
                     rowReady  <= 1'b1;
                     err_range <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            FETCH: begin
               if (col == CW'(BOARD_W - 1)) begin
                  state  <= DRAIN;
                  ram_rd <= 1'b0;
               end else begin
                  col      <= col + CW'(1);
                  ram_addr <= ram_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               state    <= COMMIT;
               Row      <= shadow_nxt;
               rowReady <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_row_server.sv
// Bench for board_row_server: timing-level reference model feeds a
// scoreboard that a negedge monitor drains on every rowReady.
module tb_board_row_server;

   localparam int W = 10;
   localparam int H = 20;

   logic              Clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              LD_Row = 1'b0;
   logic [7:0]        rowNum = '0;
   logic [7:0]        ram_addr;
   logic              ram_rd;
   logic [15:0]       ram_rdata;
   logic [W-1:0][15:0] Row;
   logic              rowReady;
   logic              busy;
   logic              err_range;

   board_row_server dut (
      .Clk       (Clk),
      .reset_n   (reset_n),
      .LD_Row    (LD_Row),
      .rowNum    (rowNum),
      .ram_addr  (ram_addr),
      .ram_rd    (ram_rd),
      .ram_rdata (ram_rdata),
      .Row       (Row),
      .rowReady  (rowReady),
      .busy      (busy),
      .err_range (err_range)
   );

   always #5 Clk = ~Clk;

   logic [15:0] mem [256];
   always @(posedge Clk)
      if (ram_rd) ram_rdata <= mem[ram_addr];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [159:0] act,
                        input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0][15:0] row;
      bit                 err;
      int                 ce;
   } exp_t;

   exp_t       sb[$];
   int         ncyc = 0;
   bit         ld_prev;
   bit         m_busy;
   int         m_ce;
   bit         m_pend;
   logic [7:0] m_prow;
   bit         m_fetch;
   int         m_fs;
   int         m_fbase;

   // A valid row is visible 11 edges after the accepting edge, a bad one at once.
   task automatic start(input logic [7:0] r);
      exp_t e;
      bit ok;
      ok = (r < H);
      m_busy = 1;
      e.err = !ok;
      e.row = '0;
      if (ok) begin
         for (int c = 0; c < W; c++) e.row[c] = mem[r * W + c];
         m_fetch = 1;
         m_fs = ncyc;
         m_fbase = r * W;
         m_ce = ncyc + W + 1;
      end else begin
         m_fetch = 0;
         m_ce = ncyc;
      end
      e.ce = m_ce;
      sb.push_back(e);
   endtask

   always @(posedge Clk) begin
      bit req;
      ncyc++;
      if (!reset_n) begin
         ld_prev = 0;
         m_busy = 0;
         m_pend = 0;
         m_fetch = 0;
         sb.delete();
      end else begin
         req = LD_Row && !ld_prev;
         ld_prev = LD_Row;
         if (m_busy && ncyc == m_ce + 1) begin
            m_busy = 0;
            if (req) start(rowNum);
            else if (m_pend) start(m_prow);
            m_pend = 0;
         end else if (m_busy) begin
            if (req) begin
               m_pend = 1;
               m_prow = rowNum;
            end
         end else if (req) begin
            start(rowNum);
         end
      end
   end

   always @(negedge Clk) begin
      exp_t e;
      bit exp_rd;
      if (!reset_n) begin
         check("reset_row", Row, '0);
         check("reset_ready", rowReady, 0);
         check("reset_busy", busy, 0);
         check("reset_rd", ram_rd, 0);
         check("reset_err", err_range, 0);
      end else begin
         exp_rd = m_fetch && ncyc >= m_fs && ncyc <= m_fs + W - 1;
         check("ram_rd", ram_rd, exp_rd);
         if (exp_rd) check("ram_addr", ram_addr, m_fbase + ncyc - m_fs);
         check("busy", busy, m_busy);
         if (rowReady) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_ready: got 1 expected 0 at cycle %0d", ncyc);
            end else begin
               e = sb.pop_front();
               check("ready_cycle", ncyc, e.ce);
               check("row", Row, e.row);
               check("err_range", err_range, e.err);
            end
         end else if (sb.size() > 0 && sb[0].ce < ncyc) begin
            checks++;
            errors++;
            $display("FAIL missing_ready: got 0 expected 1 at cycle %0d", sb[0].ce);
            void'(sb.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] r, input int hold);
      rowNum = r;
      LD_Row = 1'b1;
      tick(hold);
      LD_Row = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0A00 + 16'(i);
      #1 reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(5);

      pulse(8'd3, 2);
      tick(20);
      for (int c = 0; c < W; c++) check("row3_cell", Row[c], 16'h0A1E + 16'(c));

      pulse(8'd19, 50);
      tick(20);
      check("row19_cell0", Row[0], 16'h0ABE);

      pulse(8'd25, 1);
      tick(3);
      check("err_set", err_range, 1);
      check("oor_row", Row, '0);
      pulse(8'd0, 1);
      tick(3);
      check("err_clear", err_range, 0);
      tick(15);

      pulse(8'd5, 1);
      tick(3);
      pulse(8'd6, 1);
      tick(1);
      pulse(8'd7, 1);
      tick(30);
      check("row7_cell9", Row[9], 16'h0A4F);

      pulse(8'd8, 1);
      tick(3);
      reset_n = 1'b0;
      #1;
      check("mid_reset_row", Row, '0);
      tick(2);
      reset_n = 1'b1;
      tick(3);
      pulse(8'd8, 1);
      tick(20);
      check("row8_cell4", Row[4], 16'h0A54);

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      tick(1);
      repeat (400) begin
         LD_Row = ($urandom_range(0, 3) == 0);
         rowNum = 8'($urandom_range(0, 24));
         tick($urandom_range(1, 6));
      end
      LD_Row = 1'b0;
      tick(40);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
